// File: rtl/beepboop_uart_pkg.sv
// Shared types and constants for the message-to-UART bridge.
// Provides the TX state enum, the terminator byte and the parity helper.
package beepboop_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic [7:0] MSG_TERMINATOR  = 8'h00;
    localparam logic       UART_IDLE_LEVEL = 1'b1;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/beepboop_uart_bridge_if.sv
// Message-bit input and UART-side status bundle of the bridge.
// Ports: bit_in, bit_valid (to bridge); tx, busy, overflow, msg_done (from it).
interface beepboop_uart_bridge_if;

    logic bit_in;
    logic bit_valid;
    logic tx;
    logic busy;
    logic overflow;
    logic msg_done;

    modport master (
        output bit_in,
        output bit_valid,
        input  tx,
        input  busy,
        input  overflow,
        input  msg_done
    );

    modport slave (
        input  bit_in,
        input  bit_valid,
        output tx,
        output busy,
        output overflow,
        output msg_done
    );

endinterface

// File: rtl/beepboop_byte_fifo.sv
// Synchronous byte FIFO with show-ahead read data.
// Ports: clock, reset, push, pop, din, dout, full, empty.
module beepboop_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_pop;
    logic        do_push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot, so a full FIFO still
    // accepts the push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/beepboop_uart_bridge.sv
// Packs an MSB-first message bit stream into bytes and resends them as
// UART frames (8N1, or 8E1 when BEEPBOOP_UART_PARITY_EN is defined).
// Ports: clock, reset (sync, high), bus (slave): bit_in, bit_valid in;
// tx, busy, overflow (sticky), msg_done (pulse on 0x00 byte) out.
module beepboop_uart_bridge
    import beepboop_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    beepboop_uart_bridge_if.slave  bus
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    logic [7:0] shift_reg;
    logic [2:0] cnt;
    logic [7:0] byte_next;
    logic       byte_done;
    logic       is_term;
    logic       done_q;
    logic       ovf_q;

    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    logic [7:0] dout;

    tx_state_t  state;
    logic [BW-1:0] baud;
    logic [2:0] idx;
    logic [7:0] data;
    logic       tx_q;
    logic       baud_end;

    assign byte_next = {shift_reg[6:0], bus.bit_in};
    assign byte_done = bus.bit_valid && (cnt == 3'd7);
    assign is_term   = (byte_next == MSG_TERMINATOR);

    assign push = byte_done && !is_term;
    assign pop  = (state == IDLE) && !empty;

    beepboop_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (byte_next),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    // Deserializer: any gap in bit_valid discards the partial byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_reg <= '0;
            cnt       <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            done_q <= byte_done && is_term;
            if (push && full && !pop) ovf_q <= 1'b1;
            if (bus.bit_valid) begin
                shift_reg <= byte_next;
                cnt       <= cnt + 3'd1;
            end else begin
                cnt <= '0;
            end
        end
    end

    assign baud_end = (baud == BAUD_LAST);

    // Every non-IDLE state lasts one bit period; IDLE lasts at least
    // one cycle, which guarantees a gap between frames.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            baud  <= '0;
            idx   <= '0;
            data  <= '0;
            tx_q  <= UART_IDLE_LEVEL;
        end else begin
            unique case (state)
                IDLE: begin
                    baud <= '0;
                    tx_q <= UART_IDLE_LEVEL;
                    if (!empty) begin
                        data  <= dout;
                        tx_q  <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud  <= '0;
                        idx   <= '0;
                        tx_q  <= data[0];
                        state <= DATA;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (idx == 3'd7) begin
`ifdef BEEPBOOP_UART_PARITY_EN
                            tx_q  <= even_parity(data);
                            state <= PARITY;
`else
                            tx_q  <= UART_IDLE_LEVEL;
                            state <= STOP;
`endif
                        end else begin
                            idx  <= idx + 3'd1;
                            tx_q <= data[idx + 3'd1];
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
`ifdef BEEPBOOP_UART_PARITY_EN
                PARITY: begin
                    if (baud_end) begin
                        baud  <= '0;
                        tx_q  <= UART_IDLE_LEVEL;
                        state <= STOP;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
`endif
                STOP: begin
                    if (baud_end) begin
                        baud  <= '0;
                        state <= IDLE;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx       = tx_q;
    assign bus.busy     = (state != IDLE) || !empty;
    assign bus.overflow = ovf_q;
    assign bus.msg_done = done_q;

endmodule

// File: tb/tb_beepboop_uart_bridge.sv
// Scoreboard bench for beepboop_uart_bridge: a timing model predicts
// each frame's byte and start edge; a negedge monitor decodes tx.
module tb_beepboop_uart_bridge;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef BEEPBOOP_UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FR = (10 + PB) * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;

    beepboop_uart_bridge_if bus ();

    beepboop_uart_bridge #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         push_e;
        int         pop_e;
    } ent_t;

    ent_t acc[$];
    ent_t exp_q[$];
    int   done_q[$];
    int   ovf_e    = -1;
    int   last_pop = -1000000;
    int   epoch    = 0;
    int   nb       = 0;
    logic [7:0] sh = '0;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 0;

    function automatic void chk(string nm, int act, int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h",
                     nm, cyc, act, req);
        end
    endfunction

    function automatic void model_clear();
        acc.delete();
        exp_q.delete();
        done_q.delete();
        ovf_e    = -1;
        last_pop = -1000000;
        nb       = 0;
        epoch++;
    endfunction

    // Byte b completes at edge e. A byte waits in the FIFO until the
    // transmitter has finished the previous frame plus one idle cycle.
    function automatic void complete(input logic [7:0] b, input int e);
        int occ;
        occ = 0;
        if (b == 8'h00) begin
            done_q.push_back(e);
        end else begin
            foreach (acc[i]) if (acc[i].pop_e > e) occ++;
            if (occ >= DEPTH) begin
                if (ovf_e < 0) ovf_e = e;
            end else begin
                ent_t t;
                t.data   = b;
                t.push_e = e;
                t.pop_e  = (e + 1 > last_pop + FR + 1) ?
                           e + 1 : last_pop + FR + 1;
                last_pop = t.pop_e;
                acc.push_back(t);
                exp_q.push_back(t);
            end
        end
    endfunction

    task automatic drive(input logic v, input logic b);
        bus.bit_valid = v;
        bus.bit_in    = b;
        if (v) begin
            sh = {sh[6:0], b};
            nb++;
            if (nb == 8) begin
                complete(sh, cyc + 1);
                nb = 0;
            end
        end else begin
            nb = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) drive(1'b1, b[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0);
    endtask

    task automatic drain();
        int lim;
        lim = last_pop + FR + 3;
        while (cyc < lim) drive(1'b0, 1'b0);
        idle(2);
    endtask

    // Monitor state
    bit         in_frame = 0;
    bit         has_exp  = 0;
    int         n        = 0;
    int         f_epoch  = 0;
    logic [7:0] fdata    = '0;
    ent_t       f_exp;

    always @(negedge clk) begin
        if (chk_en) begin
            bit eb;
            eb = 0;
            foreach (acc[i])
                if (acc[i].push_e <= cyc && cyc < acc[i].pop_e + FR)
                    eb = 1;
            chk("busy", int'(bus.busy), int'(eb));
            chk("overflow", int'(bus.overflow),
                (ovf_e >= 0 && cyc >= ovf_e) ? 1 : 0);
            while (done_q.size() > 0 && done_q[0] < cyc)
                void'(done_q.pop_front());
            chk("msg_done", int'(bus.msg_done),
                (done_q.size() > 0 && done_q[0] == cyc) ? 1 : 0);

            if (in_frame && f_epoch != epoch) in_frame = 0;

            if (!in_frame) begin
                if (bus.tx == 1'b0) begin
                    in_frame = 1;
                    n        = 0;
                    f_epoch  = epoch;
                    fdata    = '0;
                    if (exp_q.size() == 0) begin
                        has_exp = 0;
                        vectors++;
                        miscompares++;
                        $display("FAIL spurious_frame cyc=%0d got=start want=idle",
                                 cyc);
                    end else begin
                        has_exp = 1;
                        f_exp   = exp_q.pop_front();
                        chk("frame_start", cyc, f_exp.pop_e);
                    end
                end
            end else begin
                n++;
                if (n == CPB - 1)
                    chk("start_bit", int'(bus.tx), 0);
                if (n >= CPB && n < 9 * CPB && (n % CPB) == CPB / 2)
                    fdata[n / CPB - 1] = bus.tx;
`ifdef BEEPBOOP_UART_PARITY_EN
                if (n == 9 * CPB + CPB / 2 && has_exp)
                    chk("parity_bit", int'(bus.tx), int'(^f_exp.data));
`endif
                if (n == FR - CPB + CPB / 2)
                    chk("stop_bit", int'(bus.tx), 1);
                if (n == FR - 1) begin
                    if (has_exp)
                        chk("frame_data", int'(fdata), int'(f_exp.data));
                    in_frame = 0;
                end
            end
        end
    end

    initial begin
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        chk_en = 1;
        chk("rst_tx", int'(bus.tx), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_overflow", int'(bus.overflow), 0);
        chk("rst_msg_done", int'(bus.msg_done), 0);

        idle(100);

        send_byte(8'h42);
        drain();

        send_byte(8'h00);
        idle(5);

        for (int i = 0; i < 5; i++) drive(1'b1, 1'($urandom_range(0, 1)));
        drive(1'b0, 1'b0);
        send_byte(8'h41);
        drain();

        send_byte(8'h42);
        send_byte(8'h43);
        drain();

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 7) == 0)
                send_byte(8'h00);
            else
                send_byte(8'($urandom_range(1, 255)));
            if ($urandom_range(0, 3) == 0) begin
                int p;
                p = $urandom_range(1, 7);
                for (int i = 0; i < p; i++)
                    drive(1'b1, 1'($urandom_range(0, 1)));
                drive(1'b0, 1'b0);
            end
            idle($urandom_range(0, FR));
        end
        drain();

        send_byte(8'h42);
        send_byte(8'h43);
        send_byte(8'h44);
        idle(2);
        rst           = 1'b1;
        bus.bit_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        chk("mid_rst_tx", int'(bus.tx), 1);
        chk("mid_rst_busy", int'(bus.busy), 0);
        idle(100);

        for (int k = 0; k < 6; k++)
            send_byte(8'($urandom_range(1, 255)));
        drain();
        chk("sticky_overflow", int'(bus.overflow), 1);
        idle(20);

        chk("missing_frames", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
